paver_ps2_tx: RTL and testbench

PS/2 host-to-device transmitter for the Paver keyboard port: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the core to the keyboard over the same PS2_CLK/PS2_DAT pair the receiver listens on. It drives both lines open-drain (low or released), implements the inhibit/request-to-send sequence, clocks out data on device-generated clock edges, and checks the device ACK. While it is busy it holds the receiver in reset so the receiver never decodes host traffic.

---
 rtl/paver_ps2_tx.sv | 210 +++++++++++++++++++++
 tb/tb_paver_ps2_tx.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/paver_ps2_tx.sv
// PS/2 host-to-device transmitter: inhibit / request-to-send, device-clocked data, ACK check.
// Optional start/packet timeouts are compiled in with `define PAVER_PS2_TX_TIMEOUT_EN.
module paver_ps2_tx #(
  parameter int INHIBIT_CYCLES   = 10000,
  parameter int REQ_SETUP_CYCLES = 16,
  parameter int FILTER_LEN       = 8,
  parameter int START_TIMEOUT    = 1245000,
  parameter int PKT_TIMEOUT      = 166000
) (
  input  logic       coreclk,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       busy,
  output logic       done,
  output logic [1:0] tx_status,
  output logic       rx_inhibit,
  input  logic       ps2clk_in,
  input  logic       ps2data_in,
  output logic       ps2clk_drive_low,
  output logic       ps2data_drive_low
);

  localparam int DLY_MAX = (INHIBIT_CYCLES > REQ_SETUP_CYCLES) ? INHIBIT_CYCLES : REQ_SETUP_CYCLES;
  localparam int DW      = $clog2(DLY_MAX + 1);

  if (FILTER_LEN < 2 || FILTER_LEN > 255 || INHIBIT_CYCLES < 1 || REQ_SETUP_CYCLES < 1 ||
      START_TIMEOUT < 1 || PKT_TIMEOUT < 1) begin : g_bad_cfg
    $error("paver_ps2_tx: parameter out of range");
  end

  typedef enum logic [2:0] {S_IDLE, S_INHIBIT, S_REQ, S_BITS, S_ACK_WAIT, S_RELEASE} state_t;

  // Line conditioning: bit 0 = clock, bit 1 = data
  logic [1:0]      raw, sync1, sync2, filt;
  logic [1:0][7:0] fcnt;
  logic            filt_clk_q, fall;

  assign raw  = {ps2data_in, ps2clk_in};
  assign fall = filt_clk_q & ~filt[0];

  always_ff @(posedge coreclk or negedge reset_n) begin
    if (!reset_n) begin
      sync1      <= 2'b11;
      sync2      <= 2'b11;
      filt       <= 2'b11;
      fcnt       <= '0;
      filt_clk_q <= 1'b1;
    end else begin
      sync1      <= raw;
      sync2      <= sync1;
      filt_clk_q <= filt[0];
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == 8'(FILTER_LEN - 1)) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 8'd1;
        end
      end
    end
  end

  state_t        state, state_d;
  logic [DW-1:0] dly, dly_d;
  logic [3:0]    edge_cnt, edge_cnt_d;
  logic [7:0]    shreg, shreg_d;
  logic          par, par_d;
  logic          clk_drv_d, dat_drv_d, done_d;
  logic [1:0]    status_d;

`ifdef PAVER_PS2_TX_TIMEOUT_EN
  localparam int TMR_MAX = (START_TIMEOUT > PKT_TIMEOUT) ? START_TIMEOUT : PKT_TIMEOUT;
  localparam int TW      = $clog2(TMR_MAX + 1);
  logic [TW-1:0] tmr, tmr_d, tmr_lim;
  logic          tmo;

  // Before edge 1 the start limit applies; afterwards the whole-packet limit
  assign tmr_lim = (state == S_BITS && edge_cnt == 4'd0) ? TW'(START_TIMEOUT) : TW'(PKT_TIMEOUT);
  assign tmo     = (state == S_BITS || state == S_ACK_WAIT) && (tmr >= tmr_lim);
`endif

  always_comb begin
    state_d    = state;
    dly_d      = dly;
    edge_cnt_d = edge_cnt;
    shreg_d    = shreg;
    par_d      = par;
    clk_drv_d  = ps2clk_drive_low;
    dat_drv_d  = ps2data_drive_low;
    done_d     = 1'b0;
    status_d   = tx_status;
`ifdef PAVER_PS2_TX_TIMEOUT_EN
    tmr_d = tmr;
    if ((state == S_BITS || state == S_ACK_WAIT) && !tmo) tmr_d = tmr + 1'b1;
`endif
    case (state)
      S_IDLE: begin
        clk_drv_d = 1'b0;
        dat_drv_d = 1'b0;
        if (tx_start) begin
          shreg_d    = tx_data;
          par_d      = ~^tx_data;
          dly_d      = '0;
          edge_cnt_d = '0;
          clk_drv_d  = 1'b1;
          state_d    = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (dly == DW'(INHIBIT_CYCLES - 1)) begin
          dly_d     = '0;
          dat_drv_d = 1'b1;
          state_d   = S_REQ;
        end else begin
          dly_d = dly + 1'b1;
        end
      end
      S_REQ: begin
        if (dly == DW'(REQ_SETUP_CYCLES - 1)) begin
          clk_drv_d = 1'b0;
          state_d   = S_BITS;
`ifdef PAVER_PS2_TX_TIMEOUT_EN
          tmr_d = '0;
`endif
        end else begin
          dly_d = dly + 1'b1;
        end
      end
      S_BITS: begin
        if (fall) begin
          edge_cnt_d = edge_cnt + 4'd1;
`ifdef PAVER_PS2_TX_TIMEOUT_EN
          if (edge_cnt == 4'd0) tmr_d = '0;
`endif
          if (edge_cnt < 4'd8) begin
            dat_drv_d = ~shreg[0];
            shreg_d   = {1'b0, shreg[7:1]};
          end else if (edge_cnt == 4'd8) begin
            dat_drv_d = ~par;
          end else begin
            dat_drv_d = 1'b0;
            state_d   = S_ACK_WAIT;
          end
        end
      end
      S_ACK_WAIT: begin
        if (fall) begin
          status_d = filt[1] ? 2'b01 : 2'b00;
          state_d  = S_RELEASE;
        end
      end
      S_RELEASE: begin
        clk_drv_d = 1'b0;
        dat_drv_d = 1'b0;
        if (filt == 2'b11) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef PAVER_PS2_TX_TIMEOUT_EN
    // Abort straight to IDLE; a dead device may never release the lines
    if (tmo && !fall) begin
      clk_drv_d = 1'b0;
      dat_drv_d = 1'b0;
      status_d  = 2'b10;
      done_d    = 1'b1;
      state_d   = S_IDLE;
    end
`endif
  end

  always_ff @(posedge coreclk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= S_IDLE;
      dly               <= '0;
      edge_cnt          <= '0;
      shreg             <= '0;
      par               <= 1'b0;
      ps2clk_drive_low  <= 1'b0;
      ps2data_drive_low <= 1'b0;
      done              <= 1'b0;
      tx_status         <= 2'b00;
`ifdef PAVER_PS2_TX_TIMEOUT_EN
      tmr               <= '0;
`endif
    end else begin
      state             <= state_d;
      dly               <= dly_d;
      edge_cnt          <= edge_cnt_d;
      shreg             <= shreg_d;
      par               <= par_d;
      ps2clk_drive_low  <= clk_drv_d;
      ps2data_drive_low <= dat_drv_d;
      done              <= done_d;
      tx_status         <= status_d;
`ifdef PAVER_PS2_TX_TIMEOUT_EN
      tmr               <= tmr_d;
`endif
    end
  end

  assign busy       = (state != S_IDLE);
  assign rx_inhibit = busy;

endmodule

// File: tb/tb_paver_ps2_tx.sv
// Bench for paver_ps2_tx: behavioural PS/2 keyboard on open-drain lines plus a done-driven scoreboard.
module tb_paver_ps2_tx;

  localparam int INH   = 50;
  localparam int REQ   = 16;
  localparam int FLEN  = 8;
  localparam int START = 1000;
  localparam int PKT   = 20000;

  logic       coreclk, reset_n;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy, done, rx_inhibit;
  logic [1:0] tx_status;
  logic       ps2clk_drive_low, ps2data_drive_low;
  logic       clk_line, dat_line;

  logic dev_clk_low, dev_dat_low, glitch;
  logic dev_en, dev_ack, dev_abort, dev_active;
  int   dev_half, dev_bit, glitch_edge;

  typedef struct { logic [7:0] data; logic par; logic [1:0] status; bit frame; } exp_t;
  typedef struct { logic [7:0] data; logic par; logic stop; } frm_t;
  exp_t exp_q[$];
  frm_t dev_q[$];
  int   tests, fails;

  assign clk_line = ~ps2clk_drive_low & ~dev_clk_low & ~glitch;
  assign dat_line = ~ps2data_drive_low & ~dev_dat_low;

  paver_ps2_tx #(
    .INHIBIT_CYCLES(INH), .REQ_SETUP_CYCLES(REQ), .FILTER_LEN(FLEN),
    .START_TIMEOUT(START), .PKT_TIMEOUT(PKT)
  ) dut (
    .coreclk(coreclk), .reset_n(reset_n), .tx_data(tx_data), .tx_start(tx_start),
    .busy(busy), .done(done), .tx_status(tx_status), .rx_inhibit(rx_inhibit),
    .ps2clk_in(clk_line), .ps2data_in(dat_line),
    .ps2clk_drive_low(ps2clk_drive_low), .ps2data_drive_low(ps2data_drive_low)
  );

  initial begin
    coreclk = 1'b0;
    forever #5 coreclk = ~coreclk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Odd parity: the parity bit makes the total count of ones odd
  function automatic logic odd_par(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += d[i];
    return (ones % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  task automatic dev_wait(input int n);
    for (int i = 0; i < n && !dev_abort; i++) begin
      @(posedge coreclk); #1;
    end
  endtask

  // Keyboard side of a host-to-device frame: 11 clocks, samples on the rising edge
  task automatic run_frame();
    logic [9:0] bits;
    frm_t f;
    bits = '0;
    dev_wait(20);
    for (int k = 1; k <= 11 && !dev_abort; k++) begin
      if (k == 11 && dev_ack) dev_dat_low = 1'b1;
      dev_wait(dev_half / 2);
      if (k == glitch_edge && !dev_abort) begin
        glitch = 1'b1;
        repeat (3) begin @(posedge coreclk); #1; end
        glitch = 1'b0;
      end
      dev_wait(dev_half - dev_half / 2);
      if (dev_abort) break;
      dev_clk_low = 1'b1;
      dev_bit = k;
      dev_wait(dev_half);
      if (k <= 10) bits[k-1] = dat_line;
      dev_clk_low = 1'b0;
    end
    if (!dev_abort) begin
      f.data = bits[7:0]; f.par = bits[8]; f.stop = bits[9];
      dev_q.push_back(f);
    end
    dev_wait(dev_half);
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    dev_bit = 0;
  endtask

  initial begin : device
    logic prev_clk;
    prev_clk = 1'b1;
    forever begin
      @(posedge coreclk); #1;
      if (dev_en && !dev_abort && clk_line && !prev_clk && !dat_line) begin
        dev_active = 1'b1;
        run_frame();
        dev_active = 1'b0;
      end
      prev_clk = clk_line;
    end
  end

  initial begin : monitor
    exp_t e;
    frm_t f;
    logic prev_done;
    prev_done = 1'b0;
    forever begin
      @(posedge coreclk); #1;
      if (reset_n && done) begin
        check("done_width", prev_done, 1'b0);
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("tx_status", tx_status, e.status);
          if (e.frame) begin
            if (dev_q.size() == 0) check("dev_frame_missing", 0, 1);
            else begin
              f = dev_q.pop_front();
              check("line_data", f.data, e.data);
              check("line_parity", f.par, e.par);
              check("line_stop", f.stop, 1'b1);
            end
          end
        end
      end
      prev_done = done;
    end
  end

  task automatic send(input logic [7:0] d, input logic ack, input bit track, input bit frame);
    exp_t e;
    int n;
    dev_ack  = ack;
    dev_half = $urandom_range(30, 50);
    tx_data  = d;
    tx_start = 1'b1;
    if (track) begin
      e.data = d; e.par = odd_par(d); e.frame = frame;
      e.status = !frame ? 2'b10 : (ack ? 2'b00 : 2'b01);
      exp_q.push_back(e);
    end
    @(posedge coreclk); #1;
    tx_start = 1'b0;
    tx_data  = 8'($urandom);
    check("busy_rise", busy, 1'b1);
    check("clk_drive_rise", ps2clk_drive_low, 1'b1);
    n = 0;
    while (ps2clk_drive_low && n < 5000) begin
      @(posedge coreclk); #1;
      n++;
    end
    check("clk_release_cycles", n, INH + REQ);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || dev_active) && n < 20000) begin
      @(posedge coreclk); #1;
      n++;
    end
    if (n >= 20000) check("idle_timeout", 1, 0);
    repeat (20) begin @(posedge coreclk); #1; end
  endtask

  task automatic wait_dev_bit(input int b);
    int n = 0;
    while (dev_bit != b && n < 20000) begin
      @(posedge coreclk); #1;
      n++;
    end
    if (n >= 20000) check("dev_bit_timeout", 1, 0);
  endtask

  initial begin : stim
    int n;
    logic [7:0] d;
    tests = 0; fails = 0;
    reset_n = 1'b0; tx_start = 1'b0; tx_data = 8'h00;
    dev_clk_low = 1'b0; dev_dat_low = 1'b0; glitch = 1'b0;
    dev_en = 1'b1; dev_ack = 1'b1; dev_abort = 1'b0; dev_active = 1'b0;
    dev_half = 40; dev_bit = 0; glitch_edge = 0;

    repeat (3) @(posedge coreclk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_status", tx_status, 2'b00);
    check("rst_rx_inhibit", rx_inhibit, 1'b0);
    check("rst_clk_drive", ps2clk_drive_low, 1'b0);
    check("rst_dat_drive", ps2data_drive_low, 1'b0);
    reset_n = 1'b1;
    repeat (5) begin @(posedge coreclk); #1; end

    send(8'hED, 1'b1, 1'b1, 1'b1);
    check("rx_inhibit_eq_busy", rx_inhibit, busy);
    wait_idle();
    send(8'h00, 1'b0, 1'b1, 1'b1);
    wait_idle();

    glitch_edge = 4;
    send(8'h3C, 1'b1, 1'b1, 1'b1);
    wait_idle();
    glitch_edge = 0;

    // Second request mid-transfer must be ignored
    send(8'hF4, 1'b1, 1'b1, 1'b1);
    wait_dev_bit(4);
    tx_data = 8'h55; tx_start = 1'b1;
    @(posedge coreclk); #1;
    tx_start = 1'b0;
    wait_idle();

    // Reset while the host is presenting bit 4 (a 0, so data is being pulled low)
    send(8'hA5, 1'b1, 1'b0, 1'b1);
    wait_dev_bit(5);
    repeat (20) begin @(posedge coreclk); #1; end
    check("pre_reset_dat_drive", ps2data_drive_low, 1'b1);
    #3 reset_n = 1'b0;
    dev_abort = 1'b1;
    #1;
    check("async_clk_release", ps2clk_drive_low, 1'b0);
    check("async_dat_release", ps2data_drive_low, 1'b0);
    check("reset_busy", busy, 1'b0);
    n = 0;
    while (dev_active && n < 1000) begin @(posedge coreclk); #1; n++; end
    repeat (5) begin @(posedge coreclk); #1; end
    reset_n = 1'b1;
    dev_abort = 1'b0;
    repeat (30) begin @(posedge coreclk); #1; end
    check("post_reset_status", tx_status, 2'b00);
    send(8'hFF, 1'b1, 1'b1, 1'b1);
    wait_idle();

    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom);
      send(d, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
      wait_idle();
    end

`ifdef PAVER_PS2_TX_TIMEOUT_EN
    dev_en = 1'b0;
    send(8'h12, 1'b1, 1'b1, 1'b0);
    n = 0;
    while (!done && n < 3000) begin @(posedge coreclk); #1; n++; end
    check("start_timeout_latency", (n >= 1000 && n <= 1002), 1);
    check("tmo_clk_release", ps2clk_drive_low, 1'b0);
    check("tmo_dat_release", ps2data_drive_low, 1'b0);
    wait_idle();
    dev_en = 1'b1;
`endif

    repeat (50) begin @(posedge coreclk); #1; end
    check("exp_queue_drained", exp_q.size(), 0);
    check("dev_queue_drained", dev_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
